// File: rtl/maverickOne_pkg.sv
// Shared constants and state type for the maverickOne core register file.
package maverickOne_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 64;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    SCRUB = 2'd1,
    READY = 2'd2
  } regfile_state_e;

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Post-reset scrub sequencer: walks registers 1..NUM_REGS-1, then raises ready_o.
module regfile_scrub_fsm
  import maverickOne_pkg::*;
#(
  parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  output logic          ready_o,
  output logic          scrub_en_o,
  output logic [AW-1:0] scrub_addr_o
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  regfile_state_e state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= RESET;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RESET and SCRUB both clear one register per edge, so the first edge after
  // release already clears register 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RESET, SCRUB: begin
        if (cnt_q == LAST) begin
          state_d = READY;
        end else begin
          state_d = SCRUB;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = RESET;
    endcase
  end

  assign ready_o      = (state_q == READY);
  assign scrub_en_o   = (state_q != READY) && !arst_i;
  assign scrub_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port, lock-tracking integer register file with post-reset scrub.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import maverickOne_pkg::*;
#(
  parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter int XLEN     = maverickOne_pkg::XLEN,
  parameter int NUM_RS   = 3,
  parameter int NUM_WR   = 2,
  parameter int NUM_LK   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                             clk_i,
  input  logic                             arst_i,
  output logic                             ready_o,
  input  logic [NUM_WR-1:0]                wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]      wr_data_i,
  input  logic [NUM_LK-1:0]                lk_en_i,
  input  logic [NUM_LK-1:0][AW-1:0]        lk_addr_i,
  input  logic [NUM_RS-1:0][AW-1:0]        rs_addr_i,
  output logic [NUM_RS-1:0][XLEN-1:0]      rs_data_o,
  output logic [NUM_REGS-1:0]              locks_o
);

  logic                scrub_en;
  logic [AW-1:0]       scrub_addr;
  logic [XLEN-1:0]     mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] locks_q, locks_d;

  regfile_scrub_fsm #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scrub (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .ready_o      (ready_o),
    .scrub_en_o   (scrub_en),
    .scrub_addr_o (scrub_addr)
  );

  // Storage has no reset; the scrub clears it. Later ports override earlier
  // ones on the same address because the last non-blocking write wins.
  always_ff @(posedge clk_i) begin
    if (scrub_en) begin
      mem_q[scrub_addr] <= '0;
    end else if (ready_o) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
          mem_q[wr_addr_i[w]] <= wr_data_i[w];
        end
      end
    end
  end

  // Unlocks are applied before locks so a same-cycle lock ends set.
  always_comb begin
    locks_d = locks_q;
    if (scrub_en) begin
      locks_d[scrub_addr] = 1'b0;
      locks_d[0]          = 1'b0;
    end else if (ready_o) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
          locks_d[wr_addr_i[w]] = 1'b0;
        end
      end
      for (int l = 0; l < NUM_LK; l++) begin
        if (lk_en_i[l] && (lk_addr_i[l] != '0)) begin
          locks_d[lk_addr_i[l]] = 1'b1;
        end
      end
      locks_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      locks_q <= '1;
    end else begin
      locks_q <= locks_d;
    end
  end

  assign locks_o = locks_q;

  always_comb begin
    for (int r = 0; r < NUM_RS; r++) begin
      rs_data_o[r] = '0;
      if (ready_o && (rs_addr_i[r] != '0)) begin
        rs_data_o[r] = mem_q[rs_addr_i[r]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w] == rs_addr_i[r])) begin
            rs_data_o[r] = wr_data_i[w];
          end
        end
`endif
      end
    end
  end

endmodule
